// File: rtl/vga_text_ctrl_pkg.sv
// Shared constants and types for the text-mode VGA controller.
// Mode timings, pipeline depth and the fetch-phase / sync-stage types.
package vga_text_ctrl_pkg;

  // Depth of the pixel pipeline that HS/VS/blank are delayed through.
  localparam int PIPE = 3;

  // 640x480@60
  localparam int M640_H_VISIBLE = 640;
  localparam int M640_H_FRONT   = 16;
  localparam int M640_H_SYNC    = 96;
  localparam int M640_H_BACK    = 48;
  localparam int M640_V_VISIBLE = 480;
  localparam int M640_V_FRONT   = 10;
  localparam int M640_V_SYNC    = 2;
  localparam int M640_V_BACK    = 33;

  // 800x600@60
  localparam int M800_H_VISIBLE = 800;
  localparam int M800_H_FRONT   = 40;
  localparam int M800_H_SYNC    = 128;
  localparam int M800_H_BACK    = 88;
  localparam int M800_V_VISIBLE = 600;
  localparam int M800_V_FRONT   = 1;
  localparam int M800_V_SYNC    = 4;
  localparam int M800_V_BACK    = 23;

  typedef enum logic [1:0] {
    PH_CELL,
    PH_FONT,
    PH_LOAD,
    PH_SHIFT
  } fetch_phase_t;

  typedef struct packed {
    logic blank;
    logic hs;
    logic vs;
  } sync_stage_t;

  localparam sync_stage_t SYNC_IDLE = '{blank: 1'b1, hs: 1'b0, vs: 1'b0};

  // Position within a glyph cell -> what the fetch sequencer does this cycle.
  function automatic fetch_phase_t phase_of(input int unsigned p);
    case (p)
      0:       phase_of = PH_CELL;
      1:       phase_of = PH_FONT;
      2:       phase_of = PH_LOAD;
      default: phase_of = PH_SHIFT;
    endcase
  endfunction

endpackage

// File: rtl/vga_text_ctrl_sync_counter.sv
// Horizontal/vertical raster counters with raw sync, active and wrap pulses.
// Holds at hcnt=vcnt=0 for the first cycle out of reset so counting starts cleanly.
module vga_sync_counter #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input  logic clk_vga,
  input  logic rst,
  output logic running,
  output logic active,
  output logic hs_raw,
  output logic vs_raw,
  output logic vis_line,
  output logic line_end,
  output logic frame_end
);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      running <= 1'b0;
      hcnt    <= '0;
      vcnt    <= '0;
    end else if (!running) begin
      running <= 1'b1;
    end else if (hcnt == HW'(H_TOTAL - 1)) begin
      hcnt <= '0;
      vcnt <= (vcnt == VW'(V_TOTAL - 1)) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  always_comb begin
    vis_line  = vcnt < VW'(V_VISIBLE);
    active    = running && (hcnt < HW'(H_VISIBLE)) && vis_line;
    hs_raw    = running && (hcnt >= HW'(H_VISIBLE + H_FRONT))
                        && (hcnt <  HW'(H_VISIBLE + H_FRONT + H_SYNC));
    vs_raw    = running && (vcnt >= VW'(V_VISIBLE + V_FRONT))
                        && (vcnt <  VW'(V_VISIBLE + V_FRONT + V_SYNC));
    line_end  = running && (hcnt == HW'(H_TOTAL - 1));
    frame_end = line_end && (vcnt == VW'(V_TOTAL - 1));
  end

endmodule

// File: rtl/vga_text_ctrl.sv
// Text-mode VGA controller: fetch sequencer, incremental cell addressing,
// glyph shifter and a fixed delay line keeping HS/VS/blank aligned with pixels.
module vga_text_ctrl
  import vga_text_ctrl_pkg::*;
#(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int CELL_W    = 8,
  parameter int CELL_H    = 16,
  parameter int ADDR_W    = 12,
  parameter int COLOR_W   = 4,
  parameter int FRAME_W   = 8,
  localparam int COLS     = H_VISIBLE / CELL_W,
  localparam int FR_W     = (CELL_H > 1) ? $clog2(CELL_H) : 1,
  localparam int PW       = $clog2(CELL_W)
) (
  input  logic                 clk_vga,
  input  logic                 rst,
  input  logic [CELL_W-1:0]    font_bits,
  input  logic [3*COLOR_W-1:0] fg_rgb,
  input  logic [3*COLOR_W-1:0] bg_rgb,
  output logic [ADDR_W-1:0]    cell_addr,
  output logic [FR_W-1:0]      font_row,
  output logic                 fetch_cell,
  output logic                 fetch_font,
  output logic                 load_nshift,
  output logic [COLOR_W-1:0]   vga_r,
  output logic [COLOR_W-1:0]   vga_g,
  output logic [COLOR_W-1:0]   vga_b,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 vga_blank,
  output logic [FRAME_W-1:0]   vga_frame
);

  logic running, active, hs_raw, vs_raw, vis_line, line_end, frame_end;
  logic [PW-1:0]          p_cnt;
  fetch_phase_t           phase;
  logic [ADDR_W-1:0]      row_base;
  logic [ADDR_W-1:0]      col;
  logic [CELL_W-1:0]      shifter;
  logic [3*COLOR_W-1:0]   fg_q, bg_q, pixel;
  sync_stage_t [PIPE-1:0] pipe;

  vga_sync_counter #(
    .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_sync (
    .clk_vga  (clk_vga),
    .rst      (rst),
    .running  (running),
    .active   (active),
    .hs_raw   (hs_raw),
    .vs_raw   (vs_raw),
    .vis_line (vis_line),
    .line_end (line_end),
    .frame_end(frame_end)
  );

  // Pixel position within the current cell, restarted at every line.
  always_ff @(posedge clk_vga) begin
    if (rst || !running || line_end) begin
      p_cnt <= '0;
    end else if (p_cnt == PW'(CELL_W - 1)) begin
      p_cnt <= '0;
    end else begin
      p_cnt <= p_cnt + 1'b1;
    end
  end

  always_comb begin
    phase       = phase_of(32'(p_cnt));
    fetch_cell  = 1'b0;
    fetch_font  = 1'b0;
    load_nshift = 1'b0;
    if (active) begin
      case (phase)
        PH_CELL: fetch_cell  = 1'b1;
        PH_FONT: fetch_font  = 1'b1;
        PH_LOAD: load_nshift = 1'b1;
        default: ;
      endcase
    end
  end

  // Row base steps by COLS once per glyph row, so no multiplier is needed.
  always_ff @(posedge clk_vga) begin
    if (rst || frame_end) begin
      col      <= '0;
      row_base <= '0;
      font_row <= '0;
    end else if (line_end) begin
      col <= '0;
      if (vis_line) begin
        if (font_row == FR_W'(CELL_H - 1)) begin
          font_row <= '0;
          row_base <= row_base + ADDR_W'(COLS);
        end else begin
          font_row <= font_row + 1'b1;
        end
      end
    end else if (fetch_cell) begin
      col <= col + 1'b1;
    end
  end

  assign cell_addr = row_base + col;

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      shifter <= '0;
      fg_q    <= '0;
      bg_q    <= '0;
    end else if (load_nshift) begin
      shifter <= font_bits;
      fg_q    <= fg_rgb;
      bg_q    <= bg_rgb;
    end else begin
      shifter <= {shifter[CELL_W-2:0], 1'b0};
    end
  end

  // Timing flags ride the same number of stages as the fetch/load path.
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      pipe <= {PIPE{SYNC_IDLE}};
    end else begin
      pipe[0] <= '{blank: !active, hs: hs_raw, vs: vs_raw};
      for (int i = 1; i < PIPE; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      vga_frame <= '0;
    end else if (pipe[PIPE-2].vs && !pipe[PIPE-1].vs) begin
      vga_frame <= vga_frame + 1'b1;
    end
  end

  assign pixel = shifter[CELL_W-1] ? fg_q : bg_q;

  always_comb begin
    {vga_r, vga_g, vga_b} = pipe[PIPE-1].blank ? '0 : pixel;
  end

  assign vga_blank = pipe[PIPE-1].blank;
  assign vga_hs    = pipe[PIPE-1].hs ? HS_POL : ~HS_POL;
  assign vga_vs    = pipe[PIPE-1].vs ? VS_POL : ~VS_POL;

endmodule
